digitizer_sync_fifo: RTL and testbench

DIGITIZER_SYNC_FIFO -- requirements
Module: digitizer_sync_fifo

---
 rtl/digitizer_sync_fifo.sv | 103 ++++++++++
 tb/tb_digitizer_sync_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/digitizer_sync_fifo.sv
// Single-clock digitizer sample FIFO with registered read data and registered status flags.
// Define DIGITIZER_FIFO_ERR_FLAGS_EN to build the OVERFLOW/UNDERFLOW error pulses.
module digitizer_sync_fifo #(
    parameter int WIDTH      = 40,
    parameter int DEPTH_LOG2 = 10,
    parameter int AFULL_VAL  = 1020,
    parameter int AEMPTY_VAL = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  WE,
    input  logic                  RE,
    input  logic [WIDTH-1:0]      DATA,
    output logic [WIDTH-1:0]      Q,
    output logic                  DVLD,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  AFULL,
    output logic                  AEMPTY,
    output logic [DEPTH_LOG2:0]   WRCNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam int                CW       = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]     AFULL_C  = CW'(AFULL_VAL);
    localparam logic [CW-1:0]     AEMPTY_C = CW'(AEMPTY_VAL);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [1:0]            rst_sync;
    logic                  run_en;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [CW-1:0]         cnt_nxt;

    // Release is seen after the first edge so the first transfer can land on the second edge.
    always_comb begin
        run_en  = |rst_sync;
        wr_acc  = run_en & WE & ~FULL;
        rd_acc  = run_en & RE & ~EMPTY;
        cnt_nxt = WRCNT;
        if (wr_acc && !rd_acc)
            cnt_nxt = WRCNT + CNT_ONE;
        else if (rd_acc && !wr_acc)
            cnt_nxt = WRCNT - CNT_ONE;
    end

    always_ff @(posedge CLK) begin
        if (wr_acc)
            mem[wr_ptr] <= DATA;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync <= 2'b00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            WRCNT    <= '0;
            Q        <= '0;
            DVLD     <= 1'b0;
            FULL     <= 1'b0;
            EMPTY    <= 1'b1;
            AFULL    <= 1'b0;
            AEMPTY   <= 1'b1;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                Q      <= mem[rd_ptr];
            end
            DVLD   <= rd_acc;
            WRCNT  <= cnt_nxt;
            FULL   <= (cnt_nxt == DEPTH_C);
            EMPTY  <= (cnt_nxt == '0);
            AFULL  <= (cnt_nxt >= AFULL_C);
            AEMPTY <= (cnt_nxt <= AEMPTY_C);
        end
    end

`ifdef DIGITIZER_FIFO_ERR_FLAGS_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            OVERFLOW  <= run_en & WE & FULL;
            UNDERFLOW <= run_en & RE & EMPTY;
        end
    end
`else
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_digitizer_sync_fifo.sv
// Bench for digitizer_sync_fifo: directed vector table, fill/full corner cases, random traffic
// against a queue model, and asynchronous reset with release timing.
module tb_digitizer_sync_fifo;

    localparam int W     = 40;
    localparam int DL2   = 10;
    localparam int DEPTH = 1 << DL2;
    localparam int AFV   = 1020;
    localparam int AEV   = 4;

    logic           CLK = 1'b0;
    logic           RESET_N;
    logic           WE, RE;
    logic [W-1:0]   DATA;
    logic [W-1:0]   Q;
    logic           DVLD, FULL, EMPTY, AFULL, AEMPTY;
    logic [DL2:0]   WRCNT;
    logic           OVERFLOW, UNDERFLOW;

    digitizer_sync_fifo #(.WIDTH(W), .DEPTH_LOG2(DL2), .AFULL_VAL(AFV), .AEMPTY_VAL(AEV)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .WE(WE), .RE(RE), .DATA(DATA), .Q(Q), .DVLD(DVLD),
        .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .AEMPTY(AEMPTY), .WRCNT(WRCNT),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    int           n_checks = 0;
    int           n_errors = 0;
    int           total_wr = 0;
    logic [W-1:0] mq[$];
    logic [W-1:0] exp_q = '0;

    typedef struct {
        logic         we;
        logic         re;
        logic [W-1:0] data;
        logic [W-1:0] q;
        logic         dvld;
        int           cnt;
        logic         empty;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_q"},      64'(Q), 64'd0);
        chk({tag, "_flags"},  64'({DVLD, FULL, EMPTY, AFULL, AEMPTY}), 64'b00101);
        chk({tag, "_wrcnt"},  64'(WRCNT), 64'd0);
        chk({tag, "_errs"},   64'({OVERFLOW, UNDERFLOW}), 64'd0);
    endtask

    // One clock of traffic, predicted from the queue model and checked after the edge.
    task automatic step(input logic we, input logic re, input logic [W-1:0] d);
        int   lvl;
        logic wacc, racc, eo, eu;
        @(negedge CLK);
        WE = we; RE = re; DATA = d;
        lvl  = mq.size();
        wacc = we && (lvl < DEPTH);
        racc = re && (lvl > 0);
        if (racc) exp_q = mq.pop_front();
        if (wacc) begin
            mq.push_back(d);
            total_wr++;
        end
`ifdef DIGITIZER_FIFO_ERR_FLAGS_EN
        eo = we && !wacc;
        eu = re && !racc;
`else
        eo = 1'b0;
        eu = 1'b0;
`endif
        lvl = mq.size();
        @(posedge CLK);
        #1;
        chk("wrcnt", 64'(WRCNT), 64'(lvl));
        chk("dvld", 64'(DVLD), 64'(racc));
        chk("q", 64'(Q), 64'(exp_q));
        chk("flags", 64'({FULL, EMPTY, AFULL, AEMPTY}),
            64'({lvl == DEPTH, lvl == 0, lvl >= AFV, lvl <= AEV}));
        chk("err_pulses", 64'({OVERFLOW, UNDERFLOW}), 64'({eo, eu}));
    endtask

    task automatic release_and_write(input logic [W-1:0] d);
        @(negedge CLK);
        WE = 1'b1; RE = 1'b0; DATA = d;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("release_edge1_blocked", 64'(WRCNT), 64'd0);
        @(posedge CLK);
        #1;
        chk("release_edge2_accept", 64'(WRCNT), 64'd1);
        mq.push_back(d);
        total_wr++;
    endtask

    initial begin
        RESET_N = 1'b0; WE = 1'b0; RE = 1'b0; DATA = '0;
        tbl[0]  = '{1'b0, 1'b1, 40'h0,  40'h55, 1'b1, 0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 40'h1,  40'h55, 1'b0, 1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 40'h2,  40'h55, 1'b0, 2, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 40'h3,  40'h55, 1'b0, 3, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 40'h4,  40'h55, 1'b0, 4, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 40'h0,  40'h1,  1'b1, 3, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 40'h0,  40'h2,  1'b1, 2, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 40'h0,  40'h3,  1'b1, 1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 40'h0,  40'h4,  1'b1, 0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 40'h0,  40'h4,  1'b0, 0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 40'hAA, 40'h4,  1'b0, 1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 40'h0,  40'hAA, 1'b1, 0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 40'h0,  40'hAA, 1'b0, 0, 1'b1};

        repeat (3) @(posedge CLK);
        #1;
        check_reset("reset");
        release_and_write(40'h55);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].we, tbl[i].re, tbl[i].data);
            chk($sformatf("tbl%0d_q", i), 64'(Q), 64'(tbl[i].q));
            chk($sformatf("tbl%0d_dvld", i), 64'(DVLD), 64'(tbl[i].dvld));
            chk($sformatf("tbl%0d_cnt", i), 64'(WRCNT), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_empty", i), 64'(EMPTY), 64'(tbl[i].empty));
        end

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, W'(100 + i));
            if (i == AFV - 2) chk("afull_before_thresh", 64'(AFULL), 64'd0);
            if (i == AFV - 1) chk("afull_at_thresh", 64'(AFULL), 64'd1);
            if (i == DEPTH - 2) chk("full_before_last", 64'(FULL), 64'd0);
            if (i == DEPTH - 1) chk("full_at_last", 64'(FULL), 64'd1);
        end
        step(1'b1, 1'b0, 40'hDEAD);
        chk("write_when_full_cnt", 64'(WRCNT), 64'(DEPTH));
`ifdef DIGITIZER_FIFO_ERR_FLAGS_EN
        chk("overflow_pulse", 64'(OVERFLOW), 64'd1);
`else
        chk("overflow_absent", 64'(OVERFLOW), 64'd0);
`endif
        step(1'b1, 1'b1, 40'hBEEF);
        chk("rw_full_cnt", 64'(WRCNT), 64'(DEPTH - 1));
        chk("rw_full_flag", 64'(FULL), 64'd0);
        chk("rw_full_oldest", 64'(Q), 64'd100);
        for (int i = 0; i < DEPTH - 1; i++)
            step(1'b0, 1'b1, '0);
        chk("drain_empty", 64'(EMPTY), 64'd1);

        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'({$urandom, $urandom}));
        chk("pointer_wraps", 64'(total_wr >= 2 * DEPTH), 64'd1);

        for (int i = 0; i < 2000 && mq.size() < 500; i++)
            step(1'b1, 1'b0, W'({$urandom, $urandom}));
        for (int i = 0; i < 2000 && mq.size() > 500; i++)
            step(1'b0, 1'b1, '0);
        chk("level_500", 64'(WRCNT), 64'd500);

        @(negedge CLK);
        #2;
        RESET_N = 1'b0; WE = 1'b0; RE = 1'b0;
        #1;
        check_reset("async_reset");
        mq.delete();
        exp_q = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset("reset_hold");
        release_and_write(40'h77);
        step(1'b0, 1'b1, '0);
        chk("post_reset_read", 64'(Q), 64'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
